ram_dp_byte_pipe: RTL and testbench
===================================

// Module: ram_dp_byte_pipe
// PURPOSE
//  Parametrised true-synchronous dual-port RAM: port A read/write with byte enables, port B read-only.
//  Successor to the single-port async-read CPU RAM. Reads are registered with 1- or 2-cycle latency
//  and a valid strobe; collision behaviour is selectable. Intended for I/D memories and shared
//  CPU/peripheral buffers.
// PARAMETERS
//  INIT_FILE  ""   memory init file; "" = all words zero
//  INIT_HEX   0    0 = $readmemb, 1 = $readmemh
//  DP         512  depth in words; need not be a power of 2
//  DW         32   data width; need not be a multiple of 8
//  MW         4    byte lanes = ceil(DW/8); top lane covers bits DW-1:8*(MW-1)
//  AW         9    word-address width; must satisfy 2**AW >= DP
//  RD_LAT     1    read latency in cycles, 1 or 2; any other value is a synthesis error
//  RDW_MODE   0    read-during-write on the same address: 0 = old data, 1 = new (merged) data
// PORTS
//  clk       in   1    clock; all activity on rising edge
//  rst       in   1    synchronous reset, active-high
//  a_req     in   1    port A access request
//  a_we      in   1    port A write (qualified by a_req)
//  a_addr    in   AW   port A word address
//  a_wdata   in   DW   port A write data
//  a_sel     in   MW   port A byte-lane enables
//  a_rvalid  out  1    port A read data valid
//  a_rdata   out  DW   port A read data
//  b_req     in   1    port B read request
//  b_addr    in   AW   port B word address
//  b_rvalid  out  1    port B read data valid
//  b_rdata   out  DW   port B read data
// BEHAVIOUR
//  - Reset: a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, all read-pipeline stages cleared.
//    Memory contents are retained, not cleared. Writes presented while rst = 1 are ignored.
//  - Write: when a_req & a_we & !rst at edge N, every lane i with a_sel[i] = 1 is updated at N.
//    a_sel = 0 performs no write. A write never produces a_rvalid.
//  - Read: when a_req & !a_we (or b_req) is sampled at edge N, the port's rvalid is 1 for exactly
//    one cycle after edge N+RD_LAT-1, with rdata valid alongside it. Back-to-back requests give
//    back-to-back rvalid (throughput 1 per cycle per port); there is no stall or backpressure.
//  - rdata holds its last valid value while rvalid = 0. It changes only when a new read completes.
//  - RD_LAT = 2: an extra output register stage; valid and data travel together through it.
//  - Out-of-range address (addr >= DP): write is dropped; read completes normally with rdata = 0.
//  - Collision: A writes address X while B reads X in the same cycle. B returns per RDW_MODE:
//    mode 0 = the word before the write; mode 1 = old word with a_sel lanes replaced by a_wdata.
//    A read-after-write on the next cycle always returns the new data.
//  - Both ports reading the same address at once is legal; both return the identical word.
//  - Reset mid-operation: any read in flight when rst is sampled high is discarded.
//    No rvalid is produced for it, including the 2-stage pipeline under RD_LAT = 2.
//  - Initial block: zero all words, then load INIT_FILE if non-empty. Simulation/FPGA init only.
// TESTING
//  1. Reset then read: rst for 2 cycles; A reads addr 0 (no file) -> a_rvalid 1 cycle later
//     (RD_LAT=1), a_rdata=0; b_rvalid=0 throughout.
//  2. Byte lanes: write 0x11223344 sel=4'hF to addr 5, then 0xAABBCCDD sel=4'b0101
//     -> read addr 5 gives 0x11BB33DD.
//  3. Collision: word 7 = 0x0; same cycle A writes 0xDEADBEEF sel=F, B reads 7
//     -> b_rdata = 0x0 (RDW_MODE=0) / 0xDEADBEEF (RDW_MODE=1).
//  4. Streaming: RD_LAT=2; B reads addrs 0..15 back-to-back -> b_rvalid high 16 consecutive cycles
//     starting 2 cycles later, data in order.
//  5. Reset mid-flight: RD_LAT=2; issue read, assert rst next cycle -> no b_rvalid;
//     b_rdata = 0 after reset; memory word unchanged on re-read.
//  6. Bounds/odd widths: DP=100, DW=20; write addr 120 dropped, read addr 120 -> 0;
//     write 0xFFFFF sel=3'b100 to addr 3 -> read 0xF0000.

Source files
------------

// File: rtl/ram_dp_byte_pipe.sv
// ram_dp_byte_pipe: dual-port RAM, port A byte-enabled read/write, port B read-only, 1/2-cycle registered reads
module ram_dp_byte_pipe #(
    parameter string INIT_FILE = "",
    parameter int    INIT_HEX  = 0,
    parameter int    DP        = 512,
    parameter int    DW        = 32,
    parameter int    MW        = 4,
    parameter int    AW        = 9,
    parameter int    RD_LAT    = 1,
    parameter int    RDW_MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [MW-1:0] a_sel,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata
);
    localparam logic [AW:0] LP_DP = (AW+1)'(DP);
    logic [DW-1:0] r_mem [0:DP-1];
    logic [DW-1:0] w_mask, w_a_old, w_b_old, w_b_val, w_a_new;
    logic          w_a_in, w_b_in, w_wr, w_a_rd, w_coll;
    logic          r_a1_v, r_b1_v;
    logic [DW-1:0] r_a1_d, r_b1_d;
    initial begin
        for (int i = 0; i < DP; i++) r_mem[i] = '0;
    end
    genvar g;
    for (g = 0; g < DW; g++) begin : g_mask
        assign w_mask[g] = a_sel[g/8];
    end
    assign w_a_in  = {1'b0, a_addr} < LP_DP;
    assign w_b_in  = {1'b0, b_addr} < LP_DP;
    assign w_wr    = a_req & a_we & w_a_in & ~rst;
    assign w_a_rd  = a_req & ~a_we;
    assign w_a_old = w_a_in ? r_mem[a_addr] : '0;
    assign w_b_old = w_b_in ? r_mem[b_addr] : '0;
    assign w_a_new = (w_a_old & ~w_mask) | (a_wdata & w_mask);
    assign w_coll  = w_wr & b_req & (b_addr == a_addr);
    assign w_b_val = (RDW_MODE != 0 && w_coll) ? (w_b_old & ~w_mask) | (a_wdata & w_mask) : w_b_old;
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[a_addr] <= w_a_new;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1_v <= 1'b0;
            r_a1_d <= '0;
            r_b1_v <= 1'b0;
            r_b1_d <= '0;
        end else begin
            r_a1_v <= w_a_rd;
            r_b1_v <= b_req;
            if (w_a_rd) r_a1_d <= w_a_old;
            if (b_req) r_b1_d <= w_b_val;
        end
    end
    if (RD_LAT == 2) begin : g_lat2
        logic          r_a2_v, r_b2_v;
        logic [DW-1:0] r_a2_d, r_b2_d;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_a2_v <= 1'b0;
                r_a2_d <= '0;
                r_b2_v <= 1'b0;
                r_b2_d <= '0;
            end else begin
                r_a2_v <= r_a1_v;
                r_b2_v <= r_b1_v;
                if (r_a1_v) r_a2_d <= r_a1_d;
                if (r_b1_v) r_b2_d <= r_b1_d;
            end
        end
        assign a_rvalid = r_a2_v;
        assign a_rdata  = r_a2_d;
        assign b_rvalid = r_b2_v;
        assign b_rdata  = r_b2_d;
    end else if (RD_LAT == 1) begin : g_lat1
        assign a_rvalid = r_a1_v;
        assign a_rdata  = r_a1_d;
        assign b_rvalid = r_b1_v;
        assign b_rdata  = r_b1_d;
    end else begin : g_bad
        $error("RD_LAT must be 1 or 2");
    end
endmodule

// File: tb/tb_ram_dp_byte_pipe.sv
// tb_ram_dp_byte_pipe: directed checks over three configurations (default, 2-cycle/new-data, 100x20)
module tb_ram_dp_byte_pipe;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    logic        x0_a_req, x0_a_we, x0_a_rvalid, x0_b_req, x0_b_rvalid;
    logic [8:0]  x0_a_addr, x0_b_addr;
    logic [31:0] x0_a_wdata, x0_a_rdata, x0_b_rdata;
    logic [3:0]  x0_a_sel;
    logic        x1_a_req, x1_a_we, x1_a_rvalid, x1_b_req, x1_b_rvalid;
    logic [8:0]  x1_a_addr, x1_b_addr;
    logic [31:0] x1_a_wdata, x1_a_rdata, x1_b_rdata;
    logic [3:0]  x1_a_sel;
    logic        x2_a_req, x2_a_we, x2_a_rvalid, x2_b_req, x2_b_rvalid;
    logic [6:0]  x2_a_addr, x2_b_addr;
    logic [19:0] x2_a_wdata, x2_a_rdata, x2_b_rdata;
    logic [2:0]  x2_a_sel;

    ram_dp_byte_pipe u0 (
        .clk(clk), .rst(rst), .a_req(x0_a_req), .a_we(x0_a_we), .a_addr(x0_a_addr),
        .a_wdata(x0_a_wdata), .a_sel(x0_a_sel), .a_rvalid(x0_a_rvalid), .a_rdata(x0_a_rdata),
        .b_req(x0_b_req), .b_addr(x0_b_addr), .b_rvalid(x0_b_rvalid), .b_rdata(x0_b_rdata)
    );
    ram_dp_byte_pipe #(.RD_LAT(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .a_req(x1_a_req), .a_we(x1_a_we), .a_addr(x1_a_addr),
        .a_wdata(x1_a_wdata), .a_sel(x1_a_sel), .a_rvalid(x1_a_rvalid), .a_rdata(x1_a_rdata),
        .b_req(x1_b_req), .b_addr(x1_b_addr), .b_rvalid(x1_b_rvalid), .b_rdata(x1_b_rdata)
    );
    ram_dp_byte_pipe #(.DP(100), .DW(20), .MW(3), .AW(7)) u2 (
        .clk(clk), .rst(rst), .a_req(x2_a_req), .a_we(x2_a_we), .a_addr(x2_a_addr),
        .a_wdata(x2_a_wdata), .a_sel(x2_a_sel), .a_rvalid(x2_a_rvalid), .a_rdata(x2_a_rdata),
        .b_req(x2_b_req), .b_addr(x2_b_addr), .b_rvalid(x2_b_rvalid), .b_rdata(x2_b_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        x0_a_req = 0; x0_a_we = 0; x0_a_addr = 0; x0_a_wdata = 0; x0_a_sel = 0; x0_b_req = 0; x0_b_addr = 0;
        x1_a_req = 0; x1_a_we = 0; x1_a_addr = 0; x1_a_wdata = 0; x1_a_sel = 0; x1_b_req = 0; x1_b_addr = 0;
        x2_a_req = 0; x2_a_we = 0; x2_a_addr = 0; x2_a_wdata = 0; x2_a_sel = 0; x2_b_req = 0; x2_b_addr = 0;
        tick();
        tick();
        chk("rst_x0_avalid", x0_a_rvalid, 0);
        chk("rst_x0_ardata", x0_a_rdata, 0);
        chk("rst_x0_bvalid", x0_b_rvalid, 0);
        chk("rst_x0_brdata", x0_b_rdata, 0);
        chk("rst_x1_bvalid", x1_b_rvalid, 0);
        chk("rst_x1_brdata", x1_b_rdata, 0);
        chk("rst_x2_avalid", x2_a_rvalid, 0);
        rst = 1'b0;
        x0_a_req = 1; x0_a_we = 0; x0_a_addr = 0;
        tick();
        chk("rd0_avalid", x0_a_rvalid, 1);
        chk("rd0_ardata", x0_a_rdata, 0);
        chk("rd0_bvalid", x0_b_rvalid, 0);
        x0_a_we = 1; x0_a_addr = 5; x0_a_wdata = 32'h11223344; x0_a_sel = 4'hF;
        tick();
        chk("wr_no_valid", x0_a_rvalid, 0);
        x0_a_wdata = 32'hAABBCCDD; x0_a_sel = 4'b0101;
        tick();
        chk("wr2_no_valid", x0_a_rvalid, 0);
        x0_a_wdata = 32'hFFFFFFFF; x0_a_sel = 4'b0000;
        tick();
        x0_a_we = 0;
        tick();
        chk("lanes_valid", x0_a_rvalid, 1);
        chk("lanes_data", x0_a_rdata, 32'h11BB33DD);
        x0_a_req = 0;
        tick();
        chk("hold_valid", x0_a_rvalid, 0);
        chk("hold_data", x0_a_rdata, 32'h11BB33DD);
        x0_a_req = 1; x0_a_we = 1; x0_a_addr = 7; x0_a_wdata = 32'hDEADBEEF; x0_a_sel = 4'hF;
        x0_b_req = 1; x0_b_addr = 7;
        tick();
        chk("coll0_bvalid", x0_b_rvalid, 1);
        chk("coll0_bdata", x0_b_rdata, 0);
        x0_a_req = 0;
        tick();
        chk("raw0_bdata", x0_b_rdata, 32'hDEADBEEF);
        x0_a_req = 1; x0_a_we = 0; x0_a_addr = 5; x0_b_addr = 5;
        tick();
        chk("same_adata", x0_a_rdata, 32'h11BB33DD);
        chk("same_bdata", x0_b_rdata, 32'h11BB33DD);
        x0_a_req = 0; x0_b_req = 0;

        x1_a_req = 1; x1_a_we = 1; x1_a_addr = 8; x1_a_wdata = 32'h12345678; x1_a_sel = 4'hF;
        tick();
        x1_a_wdata = 32'hAABBCCDD; x1_a_sel = 4'b0011; x1_b_req = 1; x1_b_addr = 8;
        tick();
        chk("coll1_lat_bvalid", x1_b_rvalid, 0);
        x1_a_req = 0; x1_b_req = 0;
        tick();
        chk("coll1_bvalid", x1_b_rvalid, 1);
        chk("coll1_bdata", x1_b_rdata, 32'h1234CCDD);
        tick();
        chk("coll1_bvalid_off", x1_b_rvalid, 0);
        x1_a_req = 1; x1_a_we = 0; x1_a_addr = 8;
        tick();
        chk("lat2_avalid_early", x1_a_rvalid, 0);
        x1_a_req = 0;
        tick();
        chk("lat2_avalid", x1_a_rvalid, 1);
        chk("lat2_adata", x1_a_rdata, 32'h1234CCDD);
        x1_a_req = 1; x1_a_we = 1; x1_a_sel = 4'hF;
        for (int i = 0; i < 16; i++) begin
            x1_a_addr = 9'(i);
            x1_a_wdata = 32'h100 + 32'(i);
            tick();
        end
        x1_a_req = 0;
        for (int k = 0; k < 18; k++) begin
            x1_b_req = (k < 16);
            x1_b_addr = 9'(k);
            tick();
            chk("stream_valid", x1_b_rvalid, (k >= 1 && k <= 16) ? 1 : 0);
            if (k >= 1 && k <= 16) chk("stream_data", x1_b_rdata, 32'h100 + 32'(k - 1));
        end
        x1_b_req = 1; x1_b_addr = 3;
        tick();
        x1_b_req = 0; rst = 1;
        x0_a_req = 1; x0_a_we = 1; x0_a_addr = 9; x0_a_wdata = 32'h55; x0_a_sel = 4'hF;
        tick();
        chk("flight_rst_bvalid", x1_b_rvalid, 0);
        chk("flight_rst_bdata", x1_b_rdata, 0);
        rst = 0; x0_a_req = 0;
        tick();
        chk("flight_after_bvalid", x1_b_rvalid, 0);
        x1_b_req = 1; x1_b_addr = 3;
        x0_a_req = 1; x0_a_we = 0; x0_a_addr = 9;
        tick();
        chk("rst_wr_ignored_valid", x0_a_rvalid, 1);
        chk("rst_wr_ignored_data", x0_a_rdata, 0);
        x1_b_req = 0; x0_a_req = 0;
        tick();
        chk("reread_bvalid", x1_b_rvalid, 1);
        chk("reread_bdata", x1_b_rdata, 32'h103);

        x2_a_req = 1; x2_a_we = 1; x2_a_addr = 7'd120; x2_a_wdata = 20'hABCDE; x2_a_sel = 3'b111;
        tick();
        x2_a_we = 0;
        tick();
        chk("oob_valid", x2_a_rvalid, 1);
        chk("oob_data", x2_a_rdata, 0);
        x2_a_we = 1; x2_a_addr = 7'd3; x2_a_wdata = 20'hFFFFF; x2_a_sel = 3'b100;
        tick();
        x2_a_we = 0;
        tick();
        chk("toplane_data", x2_a_rdata, 32'hF0000);
        x2_a_we = 1; x2_a_addr = 7'd99; x2_a_wdata = 20'h54321; x2_a_sel = 3'b111;
        tick();
        x2_a_we = 0;
        tick();
        chk("lastword_data", x2_a_rdata, 32'h54321);
        x2_a_we = 1; x2_a_addr = 7'd4; x2_a_wdata = 20'h12345; x2_a_sel = 3'b011;
        tick();
        x2_a_req = 0; x2_b_req = 1; x2_b_addr = 7'd4;
        tick();
        chk("odd_b_valid", x2_b_rvalid, 1);
        chk("odd_b_data", x2_b_rdata, 32'h02345);
        x2_b_req = 0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
